// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm buzzer path.
//  - buzz_state_t : sequencer states (IDLE, BEEP, GAP, PAUSE)
//  - ms_to_cycles : converts a duration in ms to clock cycles at a given clock rate
//  - half_cycles  : clock cycles per half period of a tone
//  - DEF_*        : default board-level timing constants
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } buzz_state_t;

  localparam int unsigned DEF_CLK_HZ      = 100_000_000;
  localparam int unsigned DEF_TONE_HZ     = 2_000;
  localparam int unsigned DEF_BEEP_MS     = 200;
  localparam int unsigned DEF_GAP_MS      = 200;
  localparam int unsigned DEF_BURST_BEEPS = 4;
  localparam int unsigned DEF_PAUSE_MS    = 800;

  // Divide first so the default 100 MHz / 800 ms case stays inside 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Free-running square-wave divider.
//  clk  : system clock
//  rst  : asynchronous active-low reset
//  run  : count while high; counter and tone are held cleared while low
//  tone : registered square wave, toggles every HALF_CYC cycles of run
module tone_gen #(
  parameter int unsigned HALF_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tone
);

  localparam int unsigned CNT_W = $clog2(HALF_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!run) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Alarm buzzer driver: turns the alarm-sound level into bursts of beeps.
//  clk         : system clock, rising edge
//  rst         : asynchronous active-low reset
//  alm_sound   : alarm-sound level (synchronous to clk)
//  mute        : silences buzz/buzz_en; sequencing keeps running
//  buzz        : registered tone square wave to the piezo
//  buzz_en     : registered amplifier enable, high while beeping and not muted
//  beep_active : registered, high while in BEEP
module alarm_buzzer_driver
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned TONE_HZ     = DEF_TONE_HZ,
  parameter int unsigned BEEP_MS     = DEF_BEEP_MS,
  parameter int unsigned GAP_MS      = DEF_GAP_MS,
  parameter int unsigned BURST_BEEPS = DEF_BURST_BEEPS,
  parameter int unsigned PAUSE_MS    = DEF_PAUSE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic alm_sound,
  input  logic mute,
  output logic buzz,
  output logic buzz_en,
  output logic beep_active
);

  localparam int unsigned HALF_CYC  = half_cycles(CLK_HZ, TONE_HZ);
  localparam int unsigned BEEP_CYC  = ms_to_cycles(CLK_HZ, BEEP_MS);
  localparam int unsigned GAP_CYC   = ms_to_cycles(CLK_HZ, GAP_MS);
  localparam int unsigned PAUSE_CYC = ms_to_cycles(CLK_HZ, PAUSE_MS);

  localparam int unsigned MAX_CYC =
      (BEEP_CYC > GAP_CYC) ? ((BEEP_CYC > PAUSE_CYC) ? BEEP_CYC : PAUSE_CYC)
                           : ((GAP_CYC > PAUSE_CYC) ? GAP_CYC : PAUSE_CYC);

  localparam int unsigned PH_W = $clog2(MAX_CYC + 1);
  localparam int unsigned B_W  = $clog2(BURST_BEEPS + 1);

  localparam logic [PH_W-1:0] BEEP_LAST  = PH_W'(BEEP_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYC - 1);
  localparam logic [PH_W-1:0] PAUSE_LAST = PH_W'(PAUSE_CYC - 1);
  localparam logic [B_W-1:0]  B_LAST     = B_W'(BURST_BEEPS);

  if (HALF_CYC == 0 || BEEP_CYC == 0 || GAP_CYC == 0 || PAUSE_CYC == 0 ||
      BURST_BEEPS == 0) begin : g_bad_params
    $error("alarm_buzzer_driver: a derived cycle count or BURST_BEEPS is zero");
  end

  buzz_state_t     state_q, state_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [B_W-1:0]  b_cnt_q, b_cnt_d;
  logic            beep_active_q, beep_active_d;
  logic            buzz_en_q, buzz_en_d;
  logic            buzz_q, buzz_d;
  logic            tone;

  // Sequencer next state.
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    b_cnt_d  = b_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (alm_sound) begin
          state_d  = BEEP;
          ph_cnt_d = '0;
          b_cnt_d  = B_W'(1);
        end
      end
      BEEP: begin
        if (ph_cnt_q == BEEP_LAST) begin
          ph_cnt_d = '0;
          state_d  = (b_cnt_q == B_LAST) ? PAUSE : GAP;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      GAP: begin
        if (ph_cnt_q == GAP_LAST) begin
          state_d  = BEEP;
          ph_cnt_d = '0;
          b_cnt_d  = b_cnt_q + B_W'(1);
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      PAUSE: begin
        if (ph_cnt_q == PAUSE_LAST) begin
          state_d  = BEEP;
          ph_cnt_d = '0;
          b_cnt_d  = B_W'(1);
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Losing the alarm overrides every phase transition.
    if (state_q != IDLE && !alm_sound) begin
      state_d  = IDLE;
      ph_cnt_d = '0;
      b_cnt_d  = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  // The divider runs one cycle ahead (run = next state is BEEP); buzz_q then
  // samples it, which puts the first buzz rise HALF_CYC cycles after BEEP entry.
  always_comb begin
    beep_active_d = (state_d == BEEP);
    buzz_en_d     = beep_active_d & ~mute;
    buzz_d        = buzz_en_d & tone;
  end

  tone_gen #(
    .HALF_CYC (HALF_CYC)
  ) u_tone_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (beep_active_d),
    .tone (tone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ph_cnt_q      <= '0;
      b_cnt_q       <= '0;
      beep_active_q <= 1'b0;
      buzz_en_q     <= 1'b0;
      buzz_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_cnt_q      <= ph_cnt_d;
      b_cnt_q       <= b_cnt_d;
      beep_active_q <= beep_active_d;
      buzz_en_q     <= buzz_en_d;
      buzz_q        <= buzz_d;
    end
  end

  assign beep_active = beep_active_q;
  assign buzz_en     = buzz_en_q;
  assign buzz        = buzz_q;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Bench for alarm_buzzer_driver: a 2-beep instance and a 1-beep instance share stimulus;
// expected outputs come from a position-in-period model of the burst pattern.
module tb_alarm_buzzer_driver;
  import alarm_pkg::*;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned TONE_HZ  = 100;
  localparam int unsigned BEEP_MS  = 20;
  localparam int unsigned GAP_MS   = 10;
  localparam int unsigned PAUSE_MS = 30;

  localparam int HALF    = 5;   // 1000 / (2*100)
  localparam int BEEP_C  = 20;  // 1000/1000*20
  localparam int GAP_C   = 10;
  localparam int PAUSE_C = 30;

  logic clk = 1'b0;
  logic rst, alm, mute;
  logic buzz0, en0, act0;
  logic buzz1, en1, act1;
  int   checks = 0;
  int   errors = 0;
  int   t0, t1;       // cycles since burst start per DUT, -1 when idle
  logic mute_s;       // mute as sampled at the last edge
  logic [2:0] e;
  logic [2:0] e1;

  always #5 clk = ~clk;

  alarm_buzzer_driver #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .BEEP_MS(BEEP_MS), .GAP_MS(GAP_MS),
    .BURST_BEEPS(2), .PAUSE_MS(PAUSE_MS)
  ) dut0 (
    .clk(clk), .rst(rst), .alm_sound(alm), .mute(mute),
    .buzz(buzz0), .buzz_en(en0), .beep_active(act0)
  );

  alarm_buzzer_driver #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .BEEP_MS(BEEP_MS), .GAP_MS(GAP_MS),
    .BURST_BEEPS(1), .PAUSE_MS(PAUSE_MS)
  ) dut1 (
    .clk(clk), .rst(rst), .alm_sound(alm), .mute(mute),
    .buzz(buzz1), .buzz_en(en1), .beep_active(act1)
  );

  function automatic int next_t(input int t, input logic a);
    if (!a) return -1;
    if (t < 0) return 0;
    return t + 1;
  endfunction

  // {beep_active, buzz_en, buzz} for a burst that started t cycles ago.
  function automatic logic [2:0] expect_out(input int t, input int beeps, input logic m);
    int period, pos, off, start;
    logic on;
    if (t < 0) return 3'b000;
    period = beeps * BEEP_C + (beeps - 1) * GAP_C + PAUSE_C;
    pos = t % period;
    on  = 1'b0;
    off = 0;
    for (int i = 0; i < beeps; i++) begin
      start = i * (BEEP_C + GAP_C);
      if (pos >= start && pos < start + BEEP_C) begin
        on  = 1'b1;
        off = pos - start;
      end
    end
    return {on, on & ~m, on & ~m & ((off / HALF) % 2 == 1)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t0     <= -1;
      t1     <= -1;
      mute_s <= 1'b0;
    end else begin
      t0     <= next_t(t0, alm);
      t1     <= next_t(t1, alm);
      mute_s <= mute;
    end
  end

  // A single-beep burst must never visit GAP.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      assert (dut1.state_q != GAP) else begin
        errors++;
        $display("FAIL no_gap_burst1 time=%0t state=%0d required!=GAP", $time, dut1.state_q);
      end
    end
  end

  task automatic test_reset();
    rst  = 1'b0;
    alm  = 1'b1;
    mute = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({act0, en0, buzz0, act1, en1, buzz1} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs got=%b required=000000", {act0, en0, buzz0, act1, en1, buzz1});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({act0, en0, buzz0} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release got act/en/buzz=%b required=110", {act0, en0, buzz0});
    end
  endtask

  task automatic test_cadence();
    repeat (170) begin
      @(negedge clk);
      e = expect_out(t0, 2, mute_s);
      checks++;
      if ({act0, en0, buzz0} !== e) begin
        errors++;
        $display("FAIL cadence t=%0d got=%b required=%b", t0, {act0, en0, buzz0}, e);
      end
    end
  endtask

  task automatic test_drop();
    bit hit = 1'b0;
    alm = 1'b0;
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      checks++;
      if ({act0, en0, buzz0} !== 3'b000) begin
        errors++;
        $display("FAIL drop_idle got=%b required=000", {act0, en0, buzz0});
      end
    end
    alm = 1'b1;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      e = expect_out(t0, 2, mute_s);
      checks++;
      if ({act0, en0, buzz0} !== e) begin
        errors++;
        $display("FAIL drop_prelude t=%0d got=%b required=%b", t0, {act0, en0, buzz0}, e);
      end
      if (t0 == 37) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL drop_reach_beep2 got=timeout required=t0==37");
    end
    alm = 1'b0;
    @(negedge clk);
    checks++;
    if ({act0, en0, buzz0, dut0.state_q} !== {3'b000, IDLE}) begin
      errors++;
      $display("FAIL drop_next_edge got=%b state=%0d required=000 IDLE",
               {act0, en0, buzz0}, dut0.state_q);
    end
    repeat ($urandom_range(1, 5)) @(negedge clk);
    alm = 1'b1;
    repeat (162) begin
      @(negedge clk);
      e = expect_out(t0, 2, mute_s);
      checks++;
      if ({act0, en0, buzz0} !== e) begin
        errors++;
        $display("FAIL drop_reraise t=%0d got=%b required=%b", t0, {act0, en0, buzz0}, e);
      end
    end
  endtask

  task automatic test_mute();
    alm = 1'b0;
    repeat (3) @(negedge clk);
    mute = 1'b1;
    alm  = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      e = expect_out(t0, 2, mute_s);
      checks++;
      if ({act0, en0, buzz0} !== e) begin
        errors++;
        $display("FAIL mute t=%0d got=%b required=%b", t0, {act0, en0, buzz0}, e);
      end
      if (t0 == 15) begin
        checks++;
        if (buzz0 !== 1'b1) begin
          errors++;
          $display("FAIL unmute_toggle got buzz=%b required=1", buzz0);
        end
      end
      if (t0 == 11) mute = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (t0 >= 0 && t0 % 80 == 8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL async_reach_beep got=timeout required=t0%%80==8");
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({act0, en0, buzz0, act1, en1, buzz1} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got=%b required=000000", {act0, en0, buzz0, act1, en1, buzz1});
    end
    @(negedge clk);
    alm = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({act0, en0, buzz0} !== 3'b000) begin
        errors++;
        $display("FAIL async_no_restart got=%b required=000", {act0, en0, buzz0});
      end
    end
    alm = 1'b1;
    repeat (30) begin
      @(negedge clk);
      e = expect_out(t0, 2, mute_s);
      checks++;
      if ({act0, en0, buzz0} !== e) begin
        errors++;
        $display("FAIL async_restart t=%0d got=%b required=%b", t0, {act0, en0, buzz0}, e);
      end
    end
  endtask

  task automatic test_burst1();
    alm = 1'b0;
    @(negedge clk);
    alm = 1'b1;
    repeat (160) begin
      @(negedge clk);
      e1 = expect_out(t1, 1, mute_s);
      checks++;
      if ({act1, en1, buzz1} !== e1) begin
        errors++;
        $display("FAIL burst1 t=%0d got=%b required=%b", t1, {act1, en1, buzz1}, e1);
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      @(negedge clk);
      e  = expect_out(t0, 2, mute_s);
      e1 = expect_out(t1, 1, mute_s);
      checks++;
      if ({act0, en0, buzz0, act1, en1, buzz1} !== {e, e1}) begin
        errors++;
        $display("FAIL random t0=%0d t1=%0d got=%b required=%b", t0, t1,
                 {act0, en0, buzz0, act1, en1, buzz1}, {e, e1});
      end
      if ($urandom_range(0, 39) == 0) alm = ~alm;
      if ($urandom_range(0, 29) == 0) mute = ~mute;
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_drop();
    test_mute();
    test_async_reset();
    test_burst1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
